// File: rtl/bipolar_ram_if.sv
// bipolar_ram_if: bus side of the bipolar TTL static RAM model.
// Master drives address, data and enables; slave returns data and status.
interface bipolar_ram_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1,
  parameter int NUM_CE = 3
);
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DIN;
  logic [NUM_CE-1:0] CE_N;
  logic              WE_N;
  logic [DATA_W-1:0] DOUT;
  logic              DOUT_OE;
  logic              CLR_BUSY;

  modport master (
    output ADDR, DIN, CE_N, WE_N,
    input  DOUT, DOUT_OE, CLR_BUSY
  );

  modport slave (
    input  ADDR, DIN, CE_N, WE_N,
    output DOUT, DOUT_OE, CLR_BUSY
  );
endinterface

// File: rtl/bipolar_ram.sv
// bipolar_ram: 82S16/7489-class RAM, level or trailing-edge write.
// Power-on clear sequencer enabled by BIPOLAR_RAM_CLEAR_EN.
module bipolar_ram #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 1,
  parameter int NUM_CE     = 3,
  parameter int INV_OUT    = 1,
  parameter int WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic         CLK_DRV,
  input  logic         RST_N,
  bipolar_ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] INV_MASK =
    (INV_OUT != 0) ? '1 : '0;

  typedef enum logic {IDLE, ARMED} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              clr_busy_q;
  logic [ADDR_W-1:0] clr_cnt_q;

  logic              sel;
  logic              wr;
  logic              hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_data;

`ifdef BIPOLAR_RAM_CLEAR_EN
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      clr_busy_q <= 1'b1;
      clr_cnt_q  <= '0;
    end else if (clr_busy_q) begin
      clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      if (&clr_cnt_q)
        clr_busy_q <= 1'b0;
    end
  end
`else
  assign clr_busy_q = 1'b0;
  assign clr_cnt_q  = '0;
`endif

  assign sel = (&(~bus.CE_N)) & ~clr_busy_q & RST_N;
  assign wr  = sel & ~bus.WE_N;

  // Trailing-edge FSM: last sample of the pulse wins
  always_ff @(posedge CLK_DRV or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else if (clr_busy_q || WRITE_MODE == 0) begin
      state_q <= IDLE;
    end else if (wr) begin
      state_q     <= ARMED;
      pend_addr_q <= bus.ADDR;
      pend_data_q <= bus.DIN;
    end else begin
      state_q <= IDLE;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.ADDR;
    mem_wdata = bus.DIN;
    if (clr_busy_q) begin
      mem_we    = RST_N;
      mem_waddr = clr_cnt_q;
      mem_wdata = CLEAR_VAL;
    end else if (WRITE_MODE == 0) begin
      mem_we = wr;
    end else if (state_q == ARMED && !wr) begin
      mem_we    = RST_N;
      mem_waddr = pend_addr_q;
      mem_wdata = pend_data_q;
    end
  end

  // Array contents survive reset, like the real part
  always_ff @(posedge CLK_DRV) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign hit = (WRITE_MODE != 0) && (state_q == ARMED) &&
               (bus.ADDR == pend_addr_q);
  assign rd_data = hit ? pend_data_q : mem_q[bus.ADDR];

  always_comb begin
    bus.DOUT    = '1;
    bus.DOUT_OE = 1'b0;
    if (sel) begin
      bus.DOUT_OE = 1'b1;
      bus.DOUT    = (bus.WE_N ? rd_data : bus.DIN) ^ INV_MASK;
    end
  end

  assign bus.CLR_BUSY = clr_busy_q;
endmodule

// File: tb/tb_bipolar_ram.sv
// tb_bipolar_ram: scoreboard bench over a level-write, a trailing-edge
// and a 16x4 instance; covers the clear sequencer when compiled in.
module tb_bipolar_ram;
`ifdef BIPOLAR_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    int         inst;
    logic [3:0] dout;
    logic       oe;
    logic       busy;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bipolar_ram_if #(.ADDR_W(8), .DATA_W(1), .NUM_CE(3)) ifa ();
  bipolar_ram_if #(.ADDR_W(8), .DATA_W(1), .NUM_CE(3)) ifb ();
  bipolar_ram_if #(.ADDR_W(4), .DATA_W(4), .NUM_CE(3)) ifc ();

  bipolar_ram #(
    .ADDR_W(8), .DATA_W(1), .NUM_CE(3),
    .INV_OUT(1), .WRITE_MODE(0), .CLEAR_VAL(1'b0)
  ) u_a (.CLK_DRV(clk), .RST_N(rst_a), .bus(ifa));

  bipolar_ram #(
    .ADDR_W(8), .DATA_W(1), .NUM_CE(3),
    .INV_OUT(1), .WRITE_MODE(1), .CLEAR_VAL(1'b0)
  ) u_b (.CLK_DRV(clk), .RST_N(rst_b), .bus(ifb));

  bipolar_ram #(
    .ADDR_W(4), .DATA_W(4), .NUM_CE(3),
    .INV_OUT(1), .WRITE_MODE(0), .CLEAR_VAL(4'hA)
  ) u_c (.CLK_DRV(clk), .RST_N(rst_c), .bus(ifc));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input int inst, input logic [3:0] d,
                          input logic oe, input logic busy,
                          input string tag);
    exp_t e;
    e.inst = inst;
    e.dout = d;
    e.oe   = oe;
    e.busy = busy;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic drive_a(input logic [2:0] ce, input logic we,
                         input logic [7:0] a, input logic d);
    ifa.CE_N = ce;
    ifa.WE_N = we;
    ifa.ADDR = a;
    ifa.DIN  = d;
  endtask

  task automatic drive_b(input logic [2:0] ce, input logic we,
                         input logic [7:0] a, input logic d);
    ifb.CE_N = ce;
    ifb.WE_N = we;
    ifb.ADDR = a;
    ifb.DIN  = d;
  endtask

  task automatic drive_c(input logic [2:0] ce, input logic we,
                         input logic [3:0] a, input logic [3:0] d);
    ifc.CE_N = ce;
    ifc.WE_N = we;
    ifc.ADDR = a;
    ifc.DIN  = d;
  endtask

  task automatic pulse_b(input logic [7:0] a, input logic d);
    drive_b(3'b000, 1'b0, a, d);
    step();
    drive_b(3'b000, 1'b1, a, 1'b0);
    step();
  endtask

  always @(negedge clk) begin : mon
    exp_t       e;
    logic [3:0] ad;
    logic       ao;
    logic       ab;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.inst)
        0: begin
          ad = {3'b000, ifa.DOUT};
          ao = ifa.DOUT_OE;
          ab = ifa.CLR_BUSY;
        end
        1: begin
          ad = {3'b000, ifb.DOUT};
          ao = ifb.DOUT_OE;
          ab = ifb.CLR_BUSY;
        end
        default: begin
          ad = ifc.DOUT;
          ao = ifc.DOUT_OE;
          ab = ifc.CLR_BUSY;
        end
      endcase
      n_vec++;
      if (ad !== e.dout || ao !== e.oe || ab !== e.busy) begin
        n_err++;
        $display("FAIL %s: got dout=%h oe=%b busy=%b, want dout=%h oe=%b busy=%b",
                 e.tag, ad, ao, ab, e.dout, e.oe, e.busy);
      end
    end
  end

  initial begin
    int n;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    drive_a(3'b000, 1'b1, 8'h00, 1'b0);
    drive_b(3'b111, 1'b1, 8'h00, 1'b0);
    drive_c(3'b000, 1'b1, 4'h0, 4'h0);
    step();
    step();
    exp_push(0, 4'h1, 1'b0, CLR, "reset_a");
    exp_push(2, 4'hF, 1'b0, CLR, "reset_c");
    step();
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;

`ifdef BIPOLAR_RAM_CLEAR_EN
    exp_push(2, 4'hF, 1'b0, 1'b1, "clr_k0");
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 5)
        drive_c(3'b000, 1'b0, 4'h3, 4'h0);
      else
        drive_c(3'b111, 1'b1, 4'h0, 4'h0);
      exp_push(2, 4'hF, 1'b0, (k < 16), "clr_busy");
    end
    for (int i = 0; i < 16; i++) begin
      step();
      drive_c(3'b000, 1'b1, 4'(i), 4'h0);
      exp_push(2, 4'h5, 1'b1, 1'b0, "clr_word");
    end
    step();
    rst_c = 1'b0;
    step();
    rst_c = 1'b1;
    for (int k = 0; k < 7; k++) step();
    rst_c = 1'b0;
    drive_c(3'b000, 1'b1, 4'h0, 4'h0);
    exp_push(2, 4'hF, 1'b0, 1'b1, "clr_rst7");
    step();
    rst_c = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16)
        exp_push(2, 4'hF, 1'b0, 1'b1, "clr_restart");
      else
        exp_push(2, 4'h5, 1'b1, 1'b0, "clr_restart_end");
    end
`else
    step();
    drive_c(3'b000, 1'b0, 4'h2, 4'hA);
    exp_push(2, 4'h5, 1'b1, 1'b0, "c_wthru");
    step();
    drive_c(3'b000, 1'b1, 4'h2, 4'h0);
    exp_push(2, 4'h5, 1'b1, 1'b0, "c_read2");
    step();
    drive_c(3'b000, 1'b0, 4'h7, 4'h3);
    exp_push(2, 4'hC, 1'b1, 1'b0, "c_wthru7");
    step();
    drive_c(3'b000, 1'b1, 4'h7, 4'h0);
    exp_push(2, 4'hC, 1'b1, 1'b0, "c_read7");
    step();
    drive_c(3'b000, 1'b1, 4'h2, 4'h0);
    exp_push(2, 4'h5, 1'b1, 1'b0, "c_keep2");
`endif

    n = 0;
    while ((ifa.CLR_BUSY || ifb.CLR_BUSY) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL clr_timeout: got busy after %0d cycles, want idle", n);
    end

    step();
    drive_a(3'b000, 1'b0, 8'h3C, 1'b1);
    exp_push(0, 4'h0, 1'b1, 1'b0, "a_wthru_3c");
    step();
    drive_a(3'b000, 1'b1, 8'h3C, 1'b0);
    exp_push(0, 4'h0, 1'b1, 1'b0, "a_read_3c");
    step();
    drive_a(3'b100, 1'b1, 8'h3C, 1'b0);
    exp_push(0, 4'h1, 1'b0, 1'b0, "a_ce2_off");
    step();
    drive_a(3'b000, 1'b0, 8'h10, 1'b0);
    exp_push(0, 4'h1, 1'b1, 1'b0, "a_wthru_10");
    step();
    drive_a(3'b000, 1'b1, 8'h10, 1'b0);
    exp_push(0, 4'h1, 1'b1, 1'b0, "a_read_10");
    step();
    drive_a(3'b001, 1'b0, 8'h3C, 1'b0);
    exp_push(0, 4'h1, 1'b0, 1'b0, "a_ce0_off_wr");
    step();
    drive_a(3'b000, 1'b1, 8'h3C, 1'b0);
    exp_push(0, 4'h0, 1'b1, 1'b0, "a_3c_kept");
    step();
    drive_a(3'b000, 1'b0, 8'h10, 1'b1);
    exp_push(0, 4'h0, 1'b1, 1'b0, "a_wthru_10b");
    step();
    drive_a(3'b000, 1'b1, 8'h10, 1'b0);
    exp_push(0, 4'h0, 1'b1, 1'b0, "a_read_10b");

    pulse_b(8'h05, 1'b0);
    pulse_b(8'h06, 1'b0);
    pulse_b(8'h04, 1'b0);
    drive_b(3'b000, 1'b0, 8'h05, 1'b0);
    exp_push(1, 4'h1, 1'b1, 1'b0, "b_wthru0");
    step();
    drive_b(3'b000, 1'b0, 8'h05, 1'b1);
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_wthru1");
    step();
    step();
    drive_b(3'b000, 1'b1, 8'h05, 1'b0);
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_bypass");
    step();
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_read_5");
    step();
    drive_b(3'b000, 1'b1, 8'h06, 1'b0);
    exp_push(1, 4'h1, 1'b1, 1'b0, "b_read_6");
    step();
    drive_b(3'b000, 1'b1, 8'h04, 1'b0);
    exp_push(1, 4'h1, 1'b1, 1'b0, "b_read_4");
    step();
    drive_b(3'b000, 1'b0, 8'h06, 1'b1);
    step();
    drive_b(3'b000, 1'b1, 8'h04, 1'b0);
    exp_push(1, 4'h1, 1'b1, 1'b0, "b_armed_other");
    step();
    drive_b(3'b000, 1'b1, 8'h06, 1'b0);
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_read_6b");
    step();
    drive_b(3'b000, 1'b0, 8'h04, 1'b1);
    step();
    drive_b(3'b111, 1'b0, 8'h04, 1'b1);
    exp_push(1, 4'h1, 1'b0, 1'b0, "b_ce_end");
    step();
    drive_b(3'b000, 1'b1, 8'h04, 1'b0);
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_read_4b");

    step();
    drive_b(3'b000, 1'b0, 8'h05, 1'b0);
    step();
    rst_b = 1'b0;
    exp_push(1, 4'h1, 1'b0, CLR, "b_rst_mid");
    step();
    rst_b = 1'b1;
    drive_b(3'b000, 1'b1, 8'h05, 1'b0);
`ifdef BIPOLAR_RAM_CLEAR_EN
    exp_push(1, 4'h1, 1'b0, 1'b1, "b_rst_clr");
    step();
`else
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_rst_keep");
    step();
    exp_push(1, 4'h0, 1'b1, 1'b0, "b_rst_nocommit");
`endif

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
